// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer and its bit counter.
// Build option: PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // Number of bit slots in one frame on the serial line.
  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Bit counter width; wide enough for the parity slot too.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial line of the PISO serializer.
// The master side is the word producer / line observer, the slave side is
// the serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             frame_active;
  logic             done;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  serial_out,
    input  frame_active,
    input  done
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output serial_out,
    output frame_active,
    output done
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Modulo-LEN bit position counter with clear, enable and last-slot flag.
// Shared between the serializer and the matching SIPO receiver.
module piso_bit_counter #(
  parameter int LEN = 4,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          is_last
);

  localparam logic [CW-1:0] LAST_VAL = CW'(LEN - 1);

  logic [CW-1:0] count_r;

  // Position register: clear wins over enable, wraps after the last slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      if (count_r == LAST_VAL) begin
        count_r <= {CW{1'b0}};
      end else begin
        count_r <= count_r + CW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count   = count_r;
  assign is_last = (count_r == LAST_VAL);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, MSB first, back-to-back capable.
// Build option: PISO_PARITY_EN sends an even-parity bit after the data bits.
// serial_out is the MSB of the shift register, so it is a pure register
// output; the shift register is zero whenever no frame is on the line.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              reset,
  piso_serializer_if.slave bus
);

  localparam int            FRAME_LEN = frame_len(WIDTH);
  localparam int            CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0] PRE_LAST  = CW'(FRAME_LEN - 2);

  piso_state_e      state_r;
  piso_state_e      state_nxt_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_nxt_s;
  logic             frame_active_r;
  logic             frame_nxt_s;
  logic             done_r;
  logic             done_nxt_s;
  logic             fill_s;
  logic [CW-1:0]    count_s;
  logic             is_last_s;
  logic             accept_s;
  logic             load_ready_s;
  logic             cnt_en_s;

`ifdef PISO_PARITY_EN
  logic parity_r;
  logic parity_nxt_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // Ready only when idle or while the last bit of a frame is on the line.
  assign load_ready_s = (state_r == IDLE) || ((state_r == SHIFT) && is_last_s);
  assign accept_s     = bus.load_valid && load_ready_s;
  assign cnt_en_s     = (state_r == SHIFT) && !accept_s;

  piso_bit_counter #(
    .LEN(FRAME_LEN),
    .CW (CW)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept_s),
    .enable (cnt_en_s),
    .count  (count_s),
    .is_last(is_last_s)
  );

  // Shift-in bit: the parity enters at the LSB on the first shift and
  // reaches the MSB exactly after the last data bit.
  always_comb begin
    fill_s = 1'b0;
`ifdef PISO_PARITY_EN
    if (count_s == {CW{1'b0}}) begin
      fill_s = parity_r;
    end else begin
      fill_s = 1'b0;
    end
`endif
  end

  // Next-state, next-shift and next-output decode.
  always_comb begin
    state_nxt_s  = state_r;
    shift_nxt_s  = shift_r;
    frame_nxt_s  = 1'b0;
    done_nxt_s   = 1'b0;
`ifdef PISO_PARITY_EN
    parity_nxt_s = parity_r;
`endif
    if (accept_s) begin
      state_nxt_s  = SHIFT;
      shift_nxt_s  = bus.data_in;
      frame_nxt_s  = 1'b1;
`ifdef PISO_PARITY_EN
      parity_nxt_s = even_parity(bus.data_in);
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
          shift_nxt_s = {WIDTH{1'b0}};
        end
        SHIFT: begin
          if (is_last_s) begin
            state_nxt_s = IDLE;
            shift_nxt_s = {WIDTH{1'b0}};
          end else begin
            state_nxt_s = SHIFT;
            shift_nxt_s = {shift_r[WIDTH-2:0], fill_s};
            frame_nxt_s = 1'b1;
            done_nxt_s  = (count_s == PRE_LAST);
          end
        end
        default: begin
          state_nxt_s = IDLE;
          shift_nxt_s = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, shift register and output registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      shift_r        <= {WIDTH{1'b0}};
      frame_active_r <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      shift_r        <= shift_nxt_s;
      frame_active_r <= frame_nxt_s;
      done_r         <= done_nxt_s;
    end
  end

`ifdef PISO_PARITY_EN
  // Parity of the captured word, held for the whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= parity_nxt_s;
    end
  end
`endif

  assign bus.load_ready   = load_ready_s;
  assign bus.serial_out   = shift_r[WIDTH-1];
  assign bus.frame_active = frame_active_r;
  assign bus.done         = done_r;

endmodule
